// File: rtl/ram_dev_pkg.sv
// ram_dev shared definitions.
// Control/status pin encodings seen by both sides of the bus.
package ram_dev_pkg;

    localparam logic [31:0] CTRL_WRITE = 32'h0000_0001;
    localparam logic [31:0] CTRL_READ  = 32'h0000_0002;

    localparam logic [31:0] STAT_IDLE  = 32'h0000_0000;
    localparam logic [31:0] STAT_DONE  = 32'h0000_0001;
    localparam logic [31:0] STAT_BUSY  = 32'h0000_0002;
    localparam logic [31:0] STAT_ERR   = 32'h0000_0004;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_READ,
        REQ_WRITE,
        REQ_BAD
    } req_e;

endpackage

// File: rtl/ram_dev_array.sv
// ram_dev storage array.
// Single-port synchronous RAM, registered read, no reset.
module ram_dev_array #(
    parameter int word_width = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [word_width-1:0] wdata_i,
    output logic [word_width-1:0] rdata_o
);

    logic [word_width-1:0] mem [DEPTH];

    // Write on enable; read port always tracks the address
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/ram_dev.sv
// ram_dev: device-side responder for the motherboard RAM port.
// ctrl/stat handshake FSM, latency counter and storage array.
module ram_dev
    import ram_dev_pkg::*;
#(
    parameter int word_width = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] ctrl,
    output logic [word_width-1:0] stat,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_in,
    output logic [word_width-1:0] data_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    localparam logic [word_width-1:0] CTRL_WR_W = word_width'(CTRL_WRITE);
    localparam logic [word_width-1:0] CTRL_RD_W = word_width'(CTRL_READ);
    localparam logic [word_width-1:0] DEPTH_W   = word_width'(DEPTH);

    localparam logic [word_width-1:0] ST_IDLE = word_width'(STAT_IDLE);
    localparam logic [word_width-1:0] ST_BUSY = word_width'(STAT_BUSY);
    localparam logic [word_width-1:0] ST_DONE = word_width'(STAT_DONE);
    localparam logic [word_width-1:0] ST_ERR  = word_width'(STAT_DONE | STAT_ERR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [word_width-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  we;
    logic [word_width-1:0] rdata;
    req_e                  req;

    // Classify the request currently on the bus
    always_comb begin
        req = REQ_NONE;
        if (ctrl == '0) begin
            req = REQ_NONE;
        end else if (addr >= DEPTH_W) begin
            req = REQ_BAD;
        end else if (ctrl == CTRL_RD_W) begin
            req = REQ_READ;
        end else if (ctrl == CTRL_WR_W) begin
            req = REQ_WRITE;
        end else begin
            req = REQ_BAD;
        end
    end

    // Handshake next-state, latch updates and status output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        we      = 1'b0;
        stat    = ST_IDLE;
        unique case (state_q)
            S_IDLE: begin
                stat = ST_IDLE;
                if (req != REQ_NONE) begin
                    addr_d  = addr[AW-1:0];
                    wdata_d = data_in;
                    wr_d    = (req == REQ_WRITE);
                    if (req == REQ_BAD) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_BUSY: begin
                stat = ST_BUSY;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    we      = wr_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                stat = ST_DONE;
                if (ctrl == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                stat = ST_ERR;
                if (ctrl == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    // The array reads addr_q on the commit edge; the word is held through DONE
    always_comb begin
        data_out = '0;
        if (state_q == S_DONE && !wr_q) begin
            data_out = rdata;
        end
    end

    ram_dev_array #(
        .word_width (word_width),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

endmodule
